// File: rtl/ow_slave_responder.sv
// ow_slave_responder: 1-wire slave answering reset/presence, then commands.
// Define OW_SLAVE_CRC_EN to append a Dallas CRC8 byte to each transmitted word.
module ow_slave_responder #(
   parameter int         T_RST_MIN = 40,
   parameter int         T_PDLY    = 3,
   parameter int         T_PRES    = 12,
   parameter int         T_SAMPLE  = 3,
   parameter int         T_HOLD    = 6,
   parameter int         TX_BITS   = 32,
   parameter logic [7:0] READ_CMD  = 8'hBE,
   parameter int         CNT_W     = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               dq_in,
   output logic               dq_pull,
   input  logic [TX_BITS-1:0] tx_data,
   input  logic               tx_load,
   output logic [7:0]         cmd_data,
   output logic               cmd_valid,
   output logic [7:0]         rx_data,
   output logic               rx_valid,
   output logic               pres_done,
   output logic               tx_done,
   output logic               busy
);

`ifdef OW_SLAVE_CRC_EN
   localparam int TX_LEN = TX_BITS + 8;
`else
   localparam int TX_LEN = TX_BITS;
`endif
   localparam int BW = $clog2(TX_LEN + 1);

   typedef enum logic [2:0] {
      IDLE, RST_WAIT, PDLY, PRES, CMD, RX, TX
   } state_t;

   state_t state, state_nxt;

   logic               dq_m, dq_s, dq_d;
   logic [CNT_W-1:0]   low_cnt, tmr;
   logic               slot_act;
   logic [BW-1:0]      bit_cnt;
   logic [6:0]         sh7;
   logic [TX_BITS-1:0] shadow, shift;
   logic [7:0]         rx_byte;
   logic fall, rise, low_inc, rst_seen;
   logic in_slots, slot_start, wr_smp, rd_end;
   logic byte_end, tx_last, pdly_end, tx_bit;
`ifdef OW_SLAVE_CRC_EN
   logic [7:0] crc, crc_nxt;
   logic       data_phase;
`endif

   assign fall     = dq_d & ~dq_s;
   assign rise     = ~dq_d & dq_s;
   assign low_inc  = ~dq_s & ~dq_pull;
   assign rst_seen = low_inc && (low_cnt == CNT_W'(T_RST_MIN - 1));

   assign in_slots   = (state == CMD) || (state == RX) || (state == TX);
   assign slot_start = in_slots && fall && !slot_act;
   assign wr_smp     = ((state == CMD) || (state == RX)) && slot_act
                       && (tmr == CNT_W'(T_SAMPLE));
   assign rd_end     = (state == TX) && slot_act && (tmr == CNT_W'(T_HOLD));
   assign byte_end   = wr_smp && (bit_cnt == BW'(7));
   assign tx_last    = rd_end && (bit_cnt == BW'(TX_LEN - 1));
   assign pdly_end   = (tmr == CNT_W'(T_PDLY - 1));
   assign rx_byte    = {dq_s, sh7};

`ifdef OW_SLAVE_CRC_EN
   assign data_phase = (bit_cnt < BW'(TX_BITS));
   assign tx_bit     = data_phase ? shift[0] : crc[0];
   assign crc_nxt    = {1'b0, crc[7:1]}
                       ^ ({8{crc[0] ^ shift[0]}} & 8'h8C);
`else
   assign tx_bit = shift[0];
`endif

   // The slave only ever drives low: presence, or a 0 bit inside a read slot
   assign dq_pull   = (state == PRES)
                      || ((state == TX) && slot_act && !tx_bit);
   assign busy      = (state != IDLE);
   assign pres_done = (state == PRES) && (tmr == CNT_W'(T_PRES - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; a detected bus reset overrides everything
   always_comb begin
      state_nxt = state;
      if (rst_seen) begin
         state_nxt = RST_WAIT;
      end else begin
         unique case (state)
            IDLE:     state_nxt = IDLE;
            RST_WAIT: if (rise) state_nxt = PDLY;
            PDLY:     if (pdly_end) state_nxt = PRES;
            PRES:     if (pres_done) state_nxt = CMD;
            CMD:      if (byte_end)
                         state_nxt = (rx_byte == READ_CMD) ? TX : RX;
            RX:       state_nxt = RX;
            TX:       if (tx_last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   // Line synchronizer, low-run timer and shadow register
   always_ff @(posedge clk) begin
      if (reset) begin
         dq_m    <= 1'b1;
         dq_s    <= 1'b1;
         dq_d    <= 1'b1;
         low_cnt <= '0;
         shadow  <= '0;
      end else begin
         dq_m <= dq_in;
         dq_s <= dq_m;
         dq_d <= dq_s;
         if (dq_s)
            low_cnt <= '0;
         else if (low_inc && (low_cnt != CNT_W'(T_RST_MIN)))
            low_cnt <= low_cnt + CNT_W'(1);
         if (tx_load) shadow <= tx_data;
      end
   end

   // Slot timing, bit shifting and result strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         tmr       <= '0;
         slot_act  <= 1'b0;
         bit_cnt   <= '0;
         sh7       <= '0;
         shift     <= '0;
         cmd_data  <= '0;
         cmd_valid <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         tx_done   <= 1'b0;
`ifdef OW_SLAVE_CRC_EN
         crc       <= '0;
`endif
      end else begin
         cmd_valid <= 1'b0;
         rx_valid  <= 1'b0;
         tx_done   <= 1'b0;
         if (rst_seen) begin
            tmr      <= '0;
            slot_act <= 1'b0;
            bit_cnt  <= '0;
         end else begin
            case (state)
               RST_WAIT: tmr <= '0;
               PDLY: tmr <= pdly_end ? '0 : tmr + CNT_W'(1);
               PRES: begin
                  if (pres_done) begin
                     tmr      <= '0;
                     bit_cnt  <= '0;
                     slot_act <= 1'b0;
                  end else begin
                     tmr <= tmr + CNT_W'(1);
                  end
               end
               CMD, RX, TX: begin
                  if (slot_start) begin
                     slot_act <= 1'b1;
                     tmr      <= CNT_W'(1);
                  end else if (slot_act) begin
                     tmr <= tmr + CNT_W'(1);
                  end
                  if (wr_smp) begin
                     slot_act <= 1'b0;
                     sh7      <= rx_byte[7:1];
                     bit_cnt  <= byte_end ? '0 : bit_cnt + BW'(1);
                  end
                  if (byte_end && (state == CMD)) begin
                     cmd_data  <= rx_byte;
                     cmd_valid <= 1'b1;
                     if (rx_byte == READ_CMD) begin
                        shift <= tx_load ? tx_data : shadow;
`ifdef OW_SLAVE_CRC_EN
                        crc   <= '0;
`endif
                     end
                  end
                  if (byte_end && (state == RX)) begin
                     rx_data  <= rx_byte;
                     rx_valid <= 1'b1;
                  end
                  if (rd_end) begin
                     slot_act <= 1'b0;
                     bit_cnt  <= tx_last ? '0 : bit_cnt + BW'(1);
                     tx_done  <= tx_last;
`ifdef OW_SLAVE_CRC_EN
                     if (data_phase) begin
                        shift <= shift >> 1;
                        crc   <= crc_nxt;
                     end else begin
                        crc <= crc >> 1;
                     end
`else
                     shift <= shift >> 1;
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ow_slave_responder.sv
// tb_ow_slave_responder: random-word bus master with reference model.
// Expected bit streams and bytes come from the protocol rules, not the RTL.
module tb_ow_slave_responder;

   localparam int TX_BITS = 32;
`ifdef OW_SLAVE_CRC_EN
   localparam int TX_LEN = TX_BITS + 8;
`else
   localparam int TX_LEN = TX_BITS;
`endif
   // 2-FF sync plus edge register, then T_PDLY wait cycles
   localparam int PRES_START = 3 + 3;
   localparam int PRES_LEN   = 12;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m_low = 1'b0;
   logic        tx_load = 1'b0;
   logic [31:0] tx_data = '0;
   logic        dq_in, dq_pull;
   logic [7:0]  cmd_data, rx_data;
   logic        cmd_valid, rx_valid, pres_done, tx_done, busy;

   // Wired-AND open-drain bus
   assign dq_in = ~(m_low | dq_pull);

   always #5 clk = ~clk;

   ow_slave_responder dut (
      .clk       (clk),
      .reset     (reset),
      .dq_in     (dq_in),
      .dq_pull   (dq_pull),
      .tx_data   (tx_data),
      .tx_load   (tx_load),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .pres_done (pres_done),
      .tx_done   (tx_done),
      .busy      (busy)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   logic [7:0] cmd_q[$];
   logic [7:0] rx_q[$];
   int pres_n = 0;
   int txd_n  = 0;

   // Collect strobes from the slave
   always @(negedge clk) begin
      if (cmd_valid) cmd_q.push_back(cmd_data);
      if (rx_valid)  rx_q.push_back(rx_data);
      if (pres_done) pres_n++;
      if (tx_done)   txd_n++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic logic [63:0] exp_stream(input logic [31:0] w);
      logic [63:0] s;
      s = '0;
      for (int i = 0; i < TX_BITS; i++) s[i] = w[i];
`ifdef OW_SLAVE_CRC_EN
      begin
         logic [7:0] c;
         c = 8'h00;
         for (int i = 0; i < TX_BITS; i++) begin
            if (c[0] ^ w[i]) c = (c >> 1) ^ 8'h8C;
            else             c = c >> 1;
         end
         for (int j = 0; j < 8; j++) s[TX_BITS + j] = c[j];
      end
`endif
      return s;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [31:0] w);
      tx_data = w;
      tx_load = 1'b1;
      cyc(1);
      tx_load = 1'b0;
   endtask

   task automatic presence(output int start, output int plen);
      start = -1;
      plen  = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (dq_pull) begin
            if (start < 0) start = k;
            plen++;
         end
      end
   endtask

   task automatic bus_reset(input int len, input string tag);
      int s, p, p0;
      p0 = pres_n;
      m_low = 1'b1;
      cyc(len);
      m_low = 1'b0;
      presence(s, p);
      check({tag, "_pstart"}, 64'(s), 64'(PRES_START));
      check({tag, "_plen"}, 64'(p), 64'(PRES_LEN));
      check({tag, "_pdone"}, 64'(pres_n - p0), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd1);
   endtask

   task automatic write_bit(input logic b);
      m_low = 1'b1;
      cyc(b ? 1 : 10);
      m_low = 1'b0;
      cyc(b ? 15 : 6);
   endtask

   task automatic write_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) write_bit(v[i]);
   endtask

   task automatic read_bit(output logic b);
      m_low = 1'b1;
      cyc(1);
      m_low = 1'b0;
      cyc(4);
      b = dq_in;
      cyc(11);
   endtask

   task automatic read_bits(input int n, input int load_at,
                            input logic [31:0] lw, output logic [63:0] v);
      logic b;
      v = '0;
      for (int i = 0; i < n; i++) begin
         if (i == load_at) load(lw);
         read_bit(b);
         v[i] = b;
      end
   endtask

   task automatic read_word(input int load_at, input logic [31:0] lw,
                            input logic [31:0] w, input string tag);
      logic [63:0] v;
      logic        b;
      int          t;
      t = txd_n;
      read_bits(TX_LEN - 1, load_at, lw, v);
      check({tag, "_early_done"}, 64'(txd_n - t), 64'd0);
      read_bit(b);
      v[TX_LEN - 1] = b;
      check({tag, "_bits"}, v, exp_stream(w));
      check({tag, "_done"}, 64'(txd_n - t), 64'd1);
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic send_cmd(input logic [7:0] c, input string tag);
      cmd_q.delete();
      write_byte(c);
      check({tag, "_ncmd"}, 64'(cmd_q.size()), 64'd1);
      if (cmd_q.size() > 0) check({tag, "_cmd"}, 64'(cmd_q[0]), 64'(c));
   endtask

   task automatic rx_bytes(input int n, input string tag);
      logic [7:0] exp_q[$];
      logic [7:0] d;
      rx_q.delete();
      for (int i = 0; i < n; i++) begin
         d = (i == 0) ? 8'h5A : (i == 1) ? 8'h01 : 8'($urandom);
         exp_q.push_back(d);
         write_byte(d);
      end
      check({tag, "_nrx"}, 64'(rx_q.size()), 64'(n));
      for (int i = 0; i < n && i < rx_q.size(); i++)
         check({tag, "_rx"}, 64'(rx_q[i]), 64'(exp_q[i]));
   endtask

   initial begin
      logic [31:0] w1, w2, w3, w;
      logic [63:0] v, mask;
      logic [7:0]  c;
      int          s, p, found;

      cyc(4);
      check("rst_outs",
            64'({dq_pull, busy, pres_done, tx_done, cmd_valid, rx_valid,
                 cmd_data, rx_data}), 64'd0);
      reset = 1'b0;
      cyc(3);
      check("idle_busy", 64'(busy), 64'd0);

      // Reset, presence, READ of a fixed word; reload mid-transfer
      w1 = 32'hAAFF00CC;
      w2 = $urandom;
      w3 = $urandom;
      load(w1);
      bus_reset(50, "r1");
      send_cmd(8'hBE, "r1");
      read_word(8, w2, w1, "r1");

      // Abort inside bit 10 by holding the line low during the slot
      bus_reset(50, "ab");
      send_cmd(8'hBE, "ab");
      read_bits(10, 5, w3, v);
      mask = (64'd1 << 10) - 64'd1;
      check("ab_pre", v & mask, exp_stream(w2) & mask);
      m_low = 1'b1;
      cyc(1);
      m_low = 1'b0;
      cyc(3);
      m_low = 1'b1;
      cyc(45);
      check("ab_release", 64'(dq_pull), 64'd0);
      m_low = 1'b0;
      presence(s, p);
      check("ab_pstart", 64'(s), 64'(PRES_START));
      check("ab_plen", 64'(p), 64'(PRES_LEN));
      send_cmd(8'hBE, "ab2");
      read_word(-1, '0, w3, "ab2");

      // Receive path
      bus_reset(50, "rx");
      send_cmd(8'h44, "rx");
      rx_bytes(4, "rx");

      // Random words and commands
      for (int it = 0; it < 4; it++) begin
         w = (it == 0) ? 32'h0 : $urandom;
         load(w);
         bus_reset(40 + int'($urandom_range(0, 20)), "rnd");
         if (it % 2 == 0) begin
            send_cmd(8'hBE, "rnd");
            read_word(-1, '0, w, "rnd");
         end else begin
            c = 8'($urandom);
            if (c == 8'hBE) c = 8'h44;
            send_cmd(c, "rndc");
            rx_bytes(2, "rnd");
         end
      end

      // Synchronous reset while presence is being driven
      m_low = 1'b1;
      cyc(50);
      m_low = 1'b0;
      found = 0;
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         if (dq_pull) begin
            found = 1;
            break;
         end
      end
      check("sr_pres_seen", 64'(found), 64'd1);
      cyc(3);
      reset = 1'b1;
      cyc(1);
      check("sr_outs",
            64'({dq_pull, busy, pres_done, tx_done, cmd_valid, rx_valid,
                 cmd_data, rx_data}), 64'd0);
      reset = 1'b0;
      cyc(5);
      check("sr_idle", 64'({dq_pull, busy}), 64'd0);
      bus_reset(50, "sr2");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
